// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch and the data stage.
// One access is in flight at a time; data wins unless fetch has lost STARVE_LIMIT times in a row.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  IFReq,
    input  logic [ADDR_WIDTH-1:0] IFAddr,
    output logic                  IFGrant,
    output logic [DATA_WIDTH-1:0] IFData,
    output logic                  IFValid,
    input  logic                  DReq,
    input  logic                  DWrite,
    input  logic [ADDR_WIDTH-1:0] DAddr,
    input  logic [DATA_WIDTH-1:0] DWData,
    output logic                  DGrant,
    output logic [DATA_WIDTH-1:0] DRData,
    output logic                  DValid,
    output logic                  MemEnable,
    output logic                  MemWrite,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic [DATA_WIDTH-1:0] MemWData,
    input  logic [DATA_WIDTH-1:0] MemRData
);

    localparam logic [3:0] LatLast   = 4'(MEM_LATENCY);
    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} stateT;
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} ownerT;

    stateT      state;
    ownerT      owner;
    logic [3:0] latCount;
    logic [3:0] starveCount;
    logic       storeOp;

    logic ifEligible;
    logic dEligible;
    logic fetchWins;

    // A side whose Valid is high is retiring; its still-high Req must not re-issue.
    always_comb begin
        ifEligible = IFReq && !IFValid;
        dEligible  = DReq && !DValid;
        fetchWins  = ifEligible && (!dEligible || (starveCount == StarveMax));
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state       <= IDLE;
            owner       <= OWN_NONE;
            latCount    <= '0;
            starveCount <= '0;
            storeOp     <= 1'b0;
            IFGrant     <= 1'b0;
            IFValid     <= 1'b0;
            IFData      <= '0;
            DGrant      <= 1'b0;
            DValid      <= 1'b0;
            DRData      <= '0;
            MemEnable   <= 1'b0;
            MemWrite    <= 1'b0;
            MemAddr     <= '0;
            MemWData    <= '0;
        end else begin
            IFGrant   <= 1'b0;
            DGrant    <= 1'b0;
            IFValid   <= 1'b0;
            DValid    <= 1'b0;
            MemEnable <= 1'b0;
            MemWrite  <= 1'b0;

            case (state)
                IDLE: begin
                    if (ifEligible || dEligible) begin
                        state     <= ISSUE;
                        MemEnable <= 1'b1;
                        if (fetchWins) begin
                            owner       <= OWN_FETCH;
                            storeOp     <= 1'b0;
                            MemAddr     <= IFAddr;
                            MemWData    <= '0;
                            IFGrant     <= 1'b1;
                            starveCount <= '0;
                        end else begin
                            owner    <= OWN_DATA;
                            storeOp  <= DWrite;
                            MemWrite <= DWrite;
                            MemAddr  <= DAddr;
                            MemWData <= DWData;
                            DGrant   <= 1'b1;
                            if (ifEligible && (starveCount != StarveMax)) begin
                                starveCount <= starveCount + 4'd1;
                            end
                        end
                    end
                end

                ISSUE: begin
                    state    <= WAIT;
                    latCount <= 4'd1;
                end

                WAIT: begin
                    if (latCount == LatLast) begin
                        state    <= IDLE;
                        owner    <= OWN_NONE;
                        latCount <= '0;
                        if (owner == OWN_FETCH) begin
                            IFData  <= MemRData;
                            IFValid <= 1'b1;
                        end else if (owner == OWN_DATA) begin
                            DRData <= storeOp ? '0 : MemRData;
                            DValid <= 1'b1;
                        end
                    end else begin
                        latCount <= latCount + 4'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    owner <= OWN_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance A uses MEM_LATENCY=2, instance B uses MEM_LATENCY=1.
// Each memory model returns data only in the exact cycle MEM_LATENCY after MemEnable.
module tb_mem_port_arbiter;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic Reset;

    logic        ifReqA, ifGrantA, ifValidA, dReqA, dWriteA, dGrantA, dValidA;
    logic        memEnableA, memWriteA;
    logic [31:0] ifAddrA, ifDataA, dAddrA, dWDataA, dRDataA, memAddrA, memWDataA, memRDataA;

    logic        ifReqB, ifGrantB, ifValidB, dReqB, dWriteB, dGrantB, dValidB;
    logic        memEnableB, memWriteB;
    logic [31:0] ifAddrB, ifDataB, dAddrB, dWDataB, dRDataB, memAddrB, memWDataB, memRDataB;

    int vectors    = 0;
    int miscompares = 0;

    function automatic logic [31:0] memFn(input logic [31:0] a);
        if (a == 32'h40) return 32'h8C220004;
        return {a[15:0], ~a[15:0]};
    endfunction

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(2), .STARVE_LIMIT(4)) dutA (
        .CLK(CLK), .Reset(Reset),
        .IFReq(ifReqA), .IFAddr(ifAddrA), .IFGrant(ifGrantA), .IFData(ifDataA), .IFValid(ifValidA),
        .DReq(dReqA), .DWrite(dWriteA), .DAddr(dAddrA), .DWData(dWDataA),
        .DGrant(dGrantA), .DRData(dRDataA), .DValid(dValidA),
        .MemEnable(memEnableA), .MemWrite(memWriteA), .MemAddr(memAddrA),
        .MemWData(memWDataA), .MemRData(memRDataA)
    );

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dutB (
        .CLK(CLK), .Reset(Reset),
        .IFReq(ifReqB), .IFAddr(ifAddrB), .IFGrant(ifGrantB), .IFData(ifDataB), .IFValid(ifValidB),
        .DReq(dReqB), .DWrite(dWriteB), .DAddr(dAddrB), .DWData(dWDataB),
        .DGrant(dGrantB), .DRData(dRDataB), .DValid(dValidB),
        .MemEnable(memEnableB), .MemWrite(memWriteB), .MemAddr(memAddrB),
        .MemWData(memWDataB), .MemRData(memRDataB)
    );

    logic        enA1 = 1'b0, enA2 = 1'b0, enB1 = 1'b0;
    logic [31:0] adA1 = '0, adA2 = '0, adB1 = '0;
    always @(posedge CLK) begin
        enA1 <= memEnableA; adA1 <= memAddrA;
        enA2 <= enA1;       adA2 <= adA1;
        enB1 <= memEnableB; adB1 <= memAddrB;
    end
    assign memRDataA = enA2 ? memFn(adA2) : 32'hBAD0BAD0;
    assign memRDataB = enB1 ? memFn(adB1) : 32'hBAD0BAD0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkAllZeroA(input string tag);
        chk({tag, "_ifgrant"}, 64'(ifGrantA), 64'd0);
        chk({tag, "_ifvalid"}, 64'(ifValidA), 64'd0);
        chk({tag, "_ifdata"}, 64'(ifDataA), 64'd0);
        chk({tag, "_dgrant"}, 64'(dGrantA), 64'd0);
        chk({tag, "_dvalid"}, 64'(dValidA), 64'd0);
        chk({tag, "_drdata"}, 64'(dRDataA), 64'd0);
        chk({tag, "_memen"}, 64'(memEnableA), 64'd0);
        chk({tag, "_memwr"}, 64'(memWriteA), 64'd0);
        chk({tag, "_memaddr"}, 64'(memAddrA), 64'd0);
        chk({tag, "_memwdata"}, 64'(memWDataA), 64'd0);
    endtask

    initial begin
        Reset  = 1'b0;
        ifReqA = 0; ifAddrA = '0; dReqA = 0; dWriteA = 0; dAddrA = '0; dWDataA = '0;
        ifReqB = 0; ifAddrB = '0; dReqB = 0; dWriteB = 0; dAddrB = '0; dWDataB = '0;
        ticks(3);

        // Reset state
        chkAllZeroA("rst");
        chk("rst_starve", 64'(dutA.starveCount), 64'd0);
        chk("rst_b_memen", 64'(memEnableB), 64'd0);
        chk("rst_b_ifdata", 64'(ifDataB), 64'd0);
        Reset = 1'b1;
        tick();

        // Uncontended fetch, Req held through the Valid cycle
        ifReqA = 1; ifAddrA = 32'h40;
        tick();
        chk("t1_ifgrant_c1", 64'(ifGrantA), 64'd1);
        chk("t1_memen_c1", 64'(memEnableA), 64'd1);
        chk("t1_memaddr_c1", 64'(memAddrA), 64'h40);
        chk("t1_memwr_c1", 64'(memWriteA), 64'd0);
        chk("t1_dgrant_c1", 64'(dGrantA), 64'd0);
        tick();
        chk("t1_memen_c2", 64'(memEnableA), 64'd0);
        chk("t1_ifgrant_c2", 64'(ifGrantA), 64'd0);
        tick();
        chk("t1_ifvalid_c3", 64'(ifValidA), 64'd0);
        tick();
        chk("t1_ifvalid_c4", 64'(ifValidA), 64'd1);
        chk("t1_ifdata_c4", 64'(ifDataA), 64'h8C220004);
        chk("t1_dvalid_c4", 64'(dValidA), 64'd0);
        tick();
        ifReqA = 0;
        chk("t1_noreissue_grant_c5", 64'(ifGrantA), 64'd0);
        chk("t1_noreissue_memen_c5", 64'(memEnableA), 64'd0);
        chk("t1_ifvalid_c5", 64'(ifValidA), 64'd0);
        chk("t1_ifdata_hold_c5", 64'(ifDataA), 64'h8C220004);
        tick();

        // Simultaneous fetch and load: data first, fetch in the data Valid cycle
        ifReqA = 1; ifAddrA = 32'h44; dReqA = 1; dWriteA = 0; dAddrA = 32'h100;
        tick();
        chk("t2_dgrant_c1", 64'(dGrantA), 64'd1);
        chk("t2_ifgrant_c1", 64'(ifGrantA), 64'd0);
        chk("t2_memaddr_c1", 64'(memAddrA), 64'h100);
        chk("t2_starve_c1", 64'(dutA.starveCount), 64'd1);
        ticks(3);
        chk("t2_dvalid_c4", 64'(dValidA), 64'd1);
        chk("t2_drdata_c4", 64'(dRDataA), 64'(memFn(32'h100)));
        chk("t2_ifvalid_c4", 64'(ifValidA), 64'd0);
        tick();
        dReqA = 0;
        chk("t2_ifgrant_c5", 64'(ifGrantA), 64'd1);
        chk("t2_dgrant_c5", 64'(dGrantA), 64'd0);
        chk("t2_memaddr_c5", 64'(memAddrA), 64'h44);
        chk("t2_starve_c5", 64'(dutA.starveCount), 64'd0);
        ticks(3);
        chk("t2_ifvalid_c8", 64'(ifValidA), 64'd1);
        chk("t2_ifdata_c8", 64'(ifDataA), 64'(memFn(32'h44)));
        tick();
        ifReqA = 0;
        tick();

        // Store
        dReqA = 1; dWriteA = 1; dAddrA = 32'h200; dWDataA = 32'hDEADBEEF;
        tick();
        chk("t3_memen_c1", 64'(memEnableA), 64'd1);
        chk("t3_memwr_c1", 64'(memWriteA), 64'd1);
        chk("t3_memwdata_c1", 64'(memWDataA), 64'hDEADBEEF);
        chk("t3_memaddr_c1", 64'(memAddrA), 64'h200);
        chk("t3_dgrant_c1", 64'(dGrantA), 64'd1);
        tick();
        chk("t3_memwr_c2", 64'(memWriteA), 64'd0);
        ticks(2);
        chk("t3_dvalid_c4", 64'(dValidA), 64'd1);
        chk("t3_drdata_c4", 64'(dRDataA), 64'd0);
        tick();
        dReqA = 0; dWriteA = 0;
        chk("t3_memen_c5", 64'(memEnableA), 64'd0);
        chk("t3_dvalid_c5", 64'(dValidA), 64'd0);
        tick();

        // Starvation: fetch loses four times, wins the fifth arbitration
        ifReqA = 1; ifAddrA = 32'h80; dReqA = 1; dWriteA = 0;
        for (int k = 0; k < 4; k++) begin
            dAddrA = 32'h300 + 32'(4 * k);
            tick();
            chk($sformatf("t4_dgrant_r%0d", k), 64'(dGrantA), 64'd1);
            chk($sformatf("t4_ifgrant_r%0d", k), 64'(ifGrantA), 64'd0);
            chk($sformatf("t4_starve_r%0d", k), 64'(dutA.starveCount), 64'(k + 1));
            ticks(3);
            chk($sformatf("t4_dvalid_r%0d", k), 64'(dValidA), 64'd1);
            chk($sformatf("t4_drdata_r%0d", k), 64'(dRDataA), 64'(memFn(32'h300 + 32'(4 * k))));
            ifReqA = 0;
            tick();
            chk($sformatf("t4_idle_r%0d", k), 64'(memEnableA), 64'd0);
            ifReqA = 1;
        end
        tick();
        chk("t4_ifgrant_r4", 64'(ifGrantA), 64'd1);
        chk("t4_dgrant_r4", 64'(dGrantA), 64'd0);
        chk("t4_memaddr_r4", 64'(memAddrA), 64'h80);
        chk("t4_starve_clear", 64'(dutA.starveCount), 64'd0);
        ticks(3);
        chk("t4_ifvalid", 64'(ifValidA), 64'd1);
        chk("t4_ifdata", 64'(ifDataA), 64'(memFn(32'h80)));
        tick();
        ifReqA = 0;
        chk("t4_dgrant_after", 64'(dGrantA), 64'd1);
        chk("t4_memaddr_after", 64'(memAddrA), 64'h30C);
        ticks(3);
        chk("t4_dvalid_after", 64'(dValidA), 64'd1);
        tick();
        dReqA = 0;
        tick();

        // Reset during WAIT of a fetch
        ifReqA = 1; ifAddrA = 32'h60;
        tick();
        chk("t5_ifgrant_c1", 64'(ifGrantA), 64'd1);
        tick();
        Reset = 1'b0;
        tick();
        Reset = 1'b1; ifReqA = 0;
        chkAllZeroA("t5_after_rst");
        chk("t5_starve", 64'(dutA.starveCount), 64'd0);
        tick();
        chk("t5_noval_c4", 64'(ifValidA), 64'd0);
        tick();
        chk("t5_noval_c5", 64'(ifValidA), 64'd0);
        tick();
        ifReqA = 1; ifAddrA = 32'h64;
        tick();
        chk("t5_new_ifgrant", 64'(ifGrantA), 64'd1);
        chk("t5_new_memaddr", 64'(memAddrA), 64'h64);
        ticks(2);
        chk("t5_new_noval_c3", 64'(ifValidA), 64'd0);
        tick();
        chk("t5_new_ifvalid_c4", 64'(ifValidA), 64'd1);
        chk("t5_new_ifdata_c4", 64'(ifDataA), 64'(memFn(32'h64)));
        tick();
        ifReqA = 0;
        tick();

        // MEM_LATENCY=1 instance: fetch held high, address advances after each Valid
        ifReqB = 1; ifAddrB = 32'h40;
        tick();
        chk("t6_ifgrant_c1", 64'(ifGrantB), 64'd1);
        chk("t6_memen_c1", 64'(memEnableB), 64'd1);
        chk("t6_memaddr_c1", 64'(memAddrB), 64'h40);
        tick();
        chk("t6_ifvalid_c2", 64'(ifValidB), 64'd0);
        tick();
        chk("t6_ifvalid_c3", 64'(ifValidB), 64'd1);
        chk("t6_ifdata_c3", 64'(ifDataB), 64'h8C220004);
        tick();
        ifAddrB = 32'h44;
        chk("t6_ifgrant_c4", 64'(ifGrantB), 64'd0);
        tick();
        chk("t6_ifgrant_c5", 64'(ifGrantB), 64'd1);
        chk("t6_memaddr_c5", 64'(memAddrB), 64'h44);
        ticks(2);
        chk("t6_ifvalid_c7", 64'(ifValidB), 64'd1);
        chk("t6_ifdata_c7", 64'(ifDataB), 64'(memFn(32'h44)));
        tick();
        ifAddrB = 32'h48;
        chk("t6_ifgrant_c8", 64'(ifGrantB), 64'd0);
        tick();
        chk("t6_ifgrant_c9", 64'(ifGrantB), 64'd1);
        tick();
        ifReqB = 0;
        tick();
        chk("t6_ifvalid_c11", 64'(ifValidB), 64'd1);
        chk("t6_ifdata_c11", 64'(ifDataB), 64'(memFn(32'h48)));
        tick();
        chk("t6_idle_c12", 64'(memEnableB), 64'd0);
        chk("t6_novalid_c12", 64'(ifValidB), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
